// File: rtl/invsqrt_share_arb.sv
// Shares one in-order, fixed-latency inverse-square-root pipe among NUM_REQ requesters.
// Round-robin grant, in-order tag FIFO routes each result back to its issuer.
module invsqrt_share_arb #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 16,
  parameter int TAG_W     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_vld,
  input  logic [NUM_REQ*16-1:0]        req_x,
  output logic [NUM_REQ-1:0]           req_rdy,
  output logic [NUM_REQ-1:0]           rsp_vld,
  output logic [15:0]                  rsp_y,
  output logic [15:0]                  pipe_x,
  output logic                         pipe_x_vld,
  input  logic [15:0]                  pipe_y,
  input  logic                         pipe_y_vld,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         err_orphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: requester i transfers in a cycle where req_vld[i] && req_rdy[i];
  // req_rdy may depend combinationally on req_vld, while req_vld must not depend on req_rdy.
  // rsp_vld and pipe_y_vld are pulses with no backpressure.

  logic               rst_rel;
  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   gnt_idx;
  logic [TAG_W-1:0]   cand;
  logic               gnt_found;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [TAG_W-1:0]   tag_mem [TAG_DEPTH];
  logic [TAG_W-1:0]   head_tag;

  assign full     = (outstanding == CNT_W'(TAG_DEPTH));
  assign empty    = (outstanding == '0);
  assign push     = rst_rel && !full && gnt_found;
  assign pop      = pipe_y_vld && !empty;
  assign head_tag = tag_mem[rd_ptr];

  // Round-robin search starting at rr_ptr, first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_found && req_vld[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Full blocks the grant even when a pop would free a slot this cycle.
  always_comb begin
    req_rdy = '0;
    if (push) req_rdy[gnt_idx] = 1'b1;
  end

  // Holds off grants for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_rel <= 1'b0;
    else        rst_rel <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= TAG_W'((int'(gnt_idx) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_x     <= '0;
      pipe_x_vld <= 1'b0;
    end else begin
      pipe_x_vld <= push;
      if (push) pipe_x <= req_x[int'(gnt_idx)*16 +: 16];
    end
  end

  // A result with nothing outstanding is dropped and flagged until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld    <= '0;
      rsp_y      <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_vld <= pop ? (NUM_REQ'(1) << head_tag) : '0;
      if (pop) rsp_y <= pipe_y;
      if (pipe_y_vld && empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: doc/invsqrt_share_arb.md
INVSQRT_SHARE_ARB -- requirements
Module: invsqrt_share_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one inverse-square-root pipe.
REQ-002 Parameter TAG_DEPTH, default 16, power of two: maximum number of issued, not-yet-returned operations.
REQ-003 Parameter TAG_W, default 2: requester-ID width, equal to clog2(NUM_REQ).
REQ-004 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port req_vld, input, NUM_REQ bits: per-requester operand valid.
REQ-007 Port req_x, input, NUM_REQ*16 bits: per-requester bf16 operand; requester i uses bits [16i+15:16i].
REQ-008 Port req_rdy, output, NUM_REQ bits: per-requester accept; this is a combinational grant.
REQ-009 Port rsp_vld, output, NUM_REQ bits: per-requester result valid pulse; it is one-hot or zero.
REQ-010 Port rsp_y, output, 16 bits: bf16 result, shared by all requesters and qualified by rsp_vld.
REQ-011 Port pipe_x, output, 16 bits: operand to the shared invsqrt pipe.
REQ-012 Port pipe_x_vld, output, 1 bit: operand valid to the pipe.
REQ-013 Port pipe_y, input, 16 bits: pipe result.
REQ-014 Port pipe_y_vld, input, 1 bit: pipe result valid.
REQ-015 Port outstanding, output, clog2(TAG_DEPTH)+1 bits: count of issued, unreturned operations.
REQ-016 Port err_orphan, output, 1 bit: sticky flag; set when a result arrives with no outstanding operation.

Function
REQ-017 Acceptance: a request transfers from requester i when req_vld[i] and req_rdy[i] are both high in the same cycle.
REQ-018 Grant conditions: at most one req_rdy bit is high per cycle, and only when req_vld of that bit is high.
- No req_rdy bit is high while the tag FIFO is full (outstanding == TAG_DEPTH).
- This holds even if a pop occurs in the same cycle.
REQ-019 Arbitration: round-robin.
- The search starts at rr_ptr and wraps modulo NUM_REQ.
- The first requester with req_vld high is granted.
- After a transfer from requester i, rr_ptr becomes (i+1) mod NUM_REQ.
- With no transfer, rr_ptr holds.
REQ-020 Issue: on a transfer from requester i, the next cycle drives pipe_x equal to that requester's req_x slice and pipe_x_vld = 1.
- pipe_x_vld = 0 in any cycle after a non-transfer cycle.
- pipe_x holds its last value when no transfer occurs.
REQ-021 Tagging: on a transfer, tag i is pushed into an in-order tag FIFO of TAG_DEPTH entries in the same cycle.
REQ-022 Return: when pipe_y_vld = 1 and the FIFO is non-empty, the head tag t is popped.
- The next cycle drives rsp_vld = one-hot(t) and rsp_y = pipe_y.
- Results return in issue order; the pipe is in-order, fixed-latency, and has no backpressure.
REQ-023 Response timing: rsp_vld is a single-cycle pulse with no backpressure.
- rsp_vld = 0 in any cycle not following a pop.
- rsp_y holds its last value when rsp_vld = 0.
REQ-024 Orphan result: when pipe_y_vld = 1 and the FIFO is empty, nothing is popped and rsp_vld stays 0.
- err_orphan is set to 1 next cycle and stays set until reset.
REQ-025 Simultaneous push and pop: push and pop are both performed in the same cycle, and outstanding is unchanged.
REQ-026 Counter update: outstanding changes by +1 on push only and by -1 on pop only.
- It never exceeds TAG_DEPTH and never underflows.
REQ-027 Pointer wrap: FIFO read and write pointers wrap modulo TAG_DEPTH.
- Full and empty are distinguished by outstanding.
REQ-028 Operand handling: operands are passed through unmodified; no arithmetic is done on data.

Reset
REQ-029 Values while rst_n = 0 (asserted asynchronously):
- req_rdy = 0 (gated by an internal reset-release register).
- rsp_vld = 0, rsp_y = 0, pipe_x = 0, pipe_x_vld = 0.
- outstanding = 0, err_orphan = 0, rr_ptr = 0.
- FIFO pointers = 0.
REQ-030 Reset mid-operation: reset discards all outstanding tags.
- Pipe results arriving after reset release with an empty FIFO set err_orphan, per REQ-024.
REQ-031 First grant: no req_rdy bit is asserted in the first cycle after rst_n deasserts.

Verification
REQ-032 Single request: req_vld = 0001, req_x[0] = 16'h4080, model pipe latency 12.
- Expect pipe_x = 16'h4080 with pipe_x_vld one cycle after the transfer.
- Expect rsp_vld = 0001 one cycle after pipe_y_vld, with rsp_y equal to the pipe_y value.
REQ-033 Round-robin under load: req_vld = 1111 held continuously.
- Grants run 0,1,2,3,0,...
- Responses arrive in the same order, each to the correct requester.
REQ-034 FIFO full: pipe latency 40 > TAG_DEPTH = 16, all requesters continuously valid.
- Exactly 16 issues occur, then req_rdy = 0 until the first pipe_y_vld.
- outstanding peaks at 16.
REQ-035 Simultaneous push and pop: at outstanding = 5, a transfer and a pipe_y_vld occur in the same cycle.
- outstanding stays 5.
- rsp_vld targets the oldest tag.
REQ-036 Orphan result: pipe_y_vld pulses with outstanding = 0.
- err_orphan = 1 next cycle and stays set; rsp_vld stays 0.
REQ-037 Reset mid-stream: assert rst_n = 0 with 7 operations outstanding.
- All outputs return to reset values immediately.
- After release and one idle cycle, a new request completes normally.
